// File: rtl/sysid_pkg.sv
// sysid_pkg: shared word map, capability-word layout and data type
// for the sysid_regs register bank.
package sysid_pkg;

   typedef logic [31:0] reg_word_t;

   localparam int ADDR_SYSID   = 0;
   localparam int ADDR_TSTAMP  = 1;
   localparam int ADDR_UPLO    = 2;
   localparam int ADDR_UPHI    = 3;
   localparam int ADDR_SCRATCH = 4;
   localparam int ADDR_CAP     = 5;
   localparam int ADDR_USER0   = 6;

   localparam int CAP_NU_LSB = 0;
   localparam int CAP_NU_W   = 8;
   localparam int CAP_AW_LSB = 8;
   localparam int CAP_AW_W   = 4;
   localparam int CAP_RL_LSB = 12;
   localparam int CAP_RL_W   = 4;

   function automatic reg_word_t cap_word(
      input int rl,
      input int aw,
      input int nu
   );
      reg_word_t w;
      w = '0;
      w[CAP_RL_LSB +: CAP_RL_W] = rl[CAP_RL_W-1:0];
      w[CAP_AW_LSB +: CAP_AW_W] = aw[CAP_AW_W-1:0];
      w[CAP_NU_LSB +: CAP_NU_W] = nu[CAP_NU_W-1:0];
      return w;
   endfunction

endpackage

// File: rtl/sysid_rdpipe.sv
// sysid_rdpipe: LAT-deep read-data pipe; clear drops every in-flight read.
// Ports: clock, clear, in_valid/in_data -> out_valid/out_data (held when idle).
module sysid_rdpipe
   import sysid_pkg::*;
#(
   parameter int LAT = 1
) (
   input  logic      clock,
   input  logic      clear,
   input  logic      in_valid,
   input  reg_word_t in_data,
   output logic      out_valid,
   output reg_word_t out_data
);

   logic [LAT-1:0] v_q;
   reg_word_t      d_q [LAT];

   // Stages only load on a valid beat, so the last stage holds its
   // data between results.
   always_ff @(posedge clock) begin
      if (clear) begin
         v_q <= '0;
         for (int i = 0; i < LAT; i++) begin
            d_q[i] <= '0;
         end
      end else begin
         v_q[0] <= in_valid;
         if (in_valid) begin
            d_q[0] <= in_data;
         end
         for (int i = 1; i < LAT; i++) begin
            v_q[i] <= v_q[i-1];
            if (v_q[i-1]) begin
               d_q[i] <= d_q[i-1];
            end
         end
      end
   end

   assign out_valid = v_q[LAT-1];
   assign out_data  = d_q[LAT-1];

endmodule

// File: rtl/sysid_regs.sv
// sysid_regs: Avalon-MM system-ID bank: ID, timestamp, 64-bit uptime with
// snapshot, scratch, capability and user words. Ports: clock, reset,
// address, read, write, writedata, readdata, readdatavalid, user_id.
module sysid_regs
   import sysid_pkg::*;
#(
   parameter reg_word_t SYSTEM_ID    = 32'h0000_0000,
   parameter reg_word_t TIMESTAMP    = 32'd0,
   parameter int        NUM_USER     = 2,
   parameter int        ADDR_W       = 4,
   parameter int        READ_LATENCY = 1,
   localparam int       UW = (NUM_USER > 0) ? NUM_USER : 1
) (
   input  logic              clock,
   input  logic              reset,
   input  logic [ADDR_W-1:0] address,
   input  logic              read,
   input  logic              write,
   input  reg_word_t         writedata,
   output reg_word_t         readdata,
   output logic              readdatavalid,
   input  logic [32*UW-1:0]  user_id
);

   if ((ADDR_USER0 + NUM_USER) > (1 << ADDR_W)
       || READ_LATENCY < 1 || READ_LATENCY > 4) begin : g_bad
      $fatal(1, "sysid_regs: illegal parameters");
   end

   logic [63:0] cnt_q, cnt_d;
   reg_word_t   shadow_q, shadow_d;
   reg_word_t   scratch_q, scratch_d;
   reg_word_t   rdata, usr_word;
   logic [31:0] a_idx;
   logic        rd_lo, wr_scr;

   assign a_idx  = 32'(address);
   assign rd_lo  = read && (a_idx == 32'(ADDR_UPLO));
   assign wr_scr = write && (a_idx == 32'(ADDR_SCRATCH));

   always_comb begin
      usr_word = '0;
      for (int i = 0; i < NUM_USER; i++) begin
         if (a_idx == 32'(ADDR_USER0 + i)) begin
            usr_word = user_id[i*32 +: 32];
         end
      end
   end

   // Read mux sees pre-write state, so a same-cycle write is not
   // observed by the read.
   always_comb begin
      rdata = '0;
      unique case (1'b1)
         (a_idx == 32'(ADDR_SYSID)):   rdata = SYSTEM_ID;
         (a_idx == 32'(ADDR_TSTAMP)):  rdata = TIMESTAMP;
         (a_idx == 32'(ADDR_UPLO)):    rdata = cnt_q[31:0];
         (a_idx == 32'(ADDR_UPHI)):    rdata = shadow_q;
         (a_idx == 32'(ADDR_SCRATCH)): rdata = scratch_q;
         (a_idx == 32'(ADDR_CAP)):
            rdata = cap_word(READ_LATENCY, ADDR_W, NUM_USER);
         default:                      rdata = usr_word;
      endcase
   end

   always_comb begin
      cnt_d     = cnt_q + 64'd1;
      shadow_d  = rd_lo ? cnt_q[63:32] : shadow_q;
      scratch_d = wr_scr ? writedata : scratch_q;
   end

   always_ff @(posedge clock) begin
      if (reset) begin
         cnt_q     <= '0;
         shadow_q  <= '0;
         scratch_q <= '0;
      end else begin
         cnt_q     <= cnt_d;
         shadow_q  <= shadow_d;
         scratch_q <= scratch_d;
      end
   end

   sysid_rdpipe #(
      .LAT(READ_LATENCY)
   ) u_pipe (
      .clock    (clock),
      .clear    (reset),
      .in_valid (read),
      .in_data  (rdata),
      .out_valid(readdatavalid),
      .out_data (readdata)
   );

endmodule

// File: tb/tb_sysid_regs.sv
// tb_sysid_regs: scoreboard bench for sysid_regs (latency-2 and
// latency-3 instances).
module tb_sysid_regs;

   localparam logic [31:0] SYS = 32'h5DE3_A24A;
   localparam logic [31:0] TS  = 32'd1575193418;
   localparam int RL  = 2;
   localparam int RL3 = 3;

   typedef struct {
      logic [31:0] data;
      int          cyc;
      int          tag;
   } exp_t;

   logic        clk = 1'b0;
   logic        rst, rst3;
   logic [3:0]  address, address3;
   logic        read, write, read3;
   logic [31:0] writedata;
   logic [31:0] readdata, readdata3;
   logic        readdatavalid, readdatavalid3;
   logic [63:0] user_id;

   int   cyc = 0;
   int   tests = 0;
   int   fails = 0;
   bit   rst_seen = 1'b1;
   logic [31:0] last = '0;
   exp_t q[$];
   exp_t q3[$];

   always #5 clk = ~clk;

   always @(posedge clk) begin
      cyc      <= cyc + 1;
      rst_seen <= rst;
   end

   sysid_regs #(
      .SYSTEM_ID(SYS), .TIMESTAMP(TS), .NUM_USER(2),
      .ADDR_W(4), .READ_LATENCY(RL)
   ) dut (
      .clock(clk), .reset(rst), .address(address),
      .read(read), .write(write), .writedata(writedata),
      .readdata(readdata), .readdatavalid(readdatavalid),
      .user_id(user_id)
   );

   sysid_regs #(
      .SYSTEM_ID(SYS), .TIMESTAMP(TS), .NUM_USER(2),
      .ADDR_W(4), .READ_LATENCY(RL3)
   ) dut3 (
      .clock(clk), .reset(rst3), .address(address3),
      .read(read3), .write(1'b0), .writedata(32'h0),
      .readdata(readdata3), .readdatavalid(readdatavalid3),
      .user_id(user_id)
   );

   task automatic chk(input string nm, input int tag,
                      input logic [63:0] act, input logic [63:0] exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s #%0d: got %h want %h", nm, tag, act, exp);
      end
   endtask

   // Main monitor: reset state, in-order data, latency, and hold.
   always @(negedge clk) begin
      if (rst_seen) begin
         chk("rst_data", 0, 64'(readdata), 64'h0);
         chk("rst_valid", 0, 64'(readdatavalid), 64'h0);
         last = '0;
      end else if (readdatavalid) begin
         if (q.size() == 0) begin
            chk("unexpected_valid", cyc, 64'(readdata), 64'hx);
         end else begin
            exp_t e;
            e = q.pop_front();
            chk("data", e.tag, 64'(readdata), 64'(e.data));
            chk("latency", e.tag, 64'(cyc), 64'(e.cyc));
         end
         last = readdata;
      end else begin
         chk("hold", cyc, 64'(readdata), 64'(last));
      end
   end

   always @(negedge clk) begin
      if (readdatavalid3) begin
         if (q3.size() == 0) begin
            chk("dut3_unexpected_valid", cyc, 64'(readdata3), 64'hx);
         end else begin
            exp_t e;
            e = q3.pop_front();
            chk("dut3_data", e.tag, 64'(readdata3), 64'(e.data));
            chk("dut3_latency", e.tag, 64'(cyc), 64'(e.cyc));
         end
      end
   end

   task automatic op(input logic r, input logic w, input int a,
                     input logic [31:0] wd, input logic [31:0] exp,
                     input int tag);
      @(negedge clk);
      read      = r;
      write     = w;
      address   = 4'(a);
      writedata = wd;
      if (r) q.push_back('{data: exp, cyc: cyc + RL, tag: tag});
   endtask

   task automatic idle(input int n);
      repeat (n) begin
         @(negedge clk);
         read  = 1'b0;
         write = 1'b0;
      end
   endtask

   initial begin
      int rel;
      rst = 1'b1; rst3 = 1'b1;
      read = 0; write = 0; address = 0; writedata = 0;
      read3 = 0; address3 = 0;
      user_id = {32'hB, 32'hA};
      repeat (3) @(negedge clk);
      rst = 1'b0; rst3 = 1'b0;
      idle(2);

      // ID and timestamp back to back
      op(1, 0, 0, 0, SYS, 1);
      op(1, 0, 1, 0, TS, 2);
      idle(3);

      // scratch write visible next cycle; ID is read-only
      op(0, 1, 4, 32'hDEAD_BEEF, 0, 0);
      op(1, 0, 4, 0, 32'hDEAD_BEEF, 3);
      op(0, 1, 0, 32'h1234, 0, 0);
      op(1, 0, 0, 0, SYS, 4);
      idle(3);

      // CAP, user words, unmapped
      op(1, 0, 5, 0, 32'h0000_2402, 5);
      op(1, 0, 6, 0, 32'hA, 6);
      op(1, 0, 7, 0, 32'hB, 7);
      op(1, 0, 8, 0, 32'h0, 8);
      op(1, 0, 15, 0, 32'h0, 9);
      idle(3);

      // same-cycle read+write returns old value
      op(0, 1, 4, 32'd5, 0, 0);
      op(1, 1, 4, 32'd9, 32'd5, 10);
      op(1, 0, 4, 0, 32'd9, 11);
      idle(3);

      // snapshot: LO then HI three cycles later
      @(negedge clk);
      dut.cnt_q = 64'h0000_0001_FFFF_FFFF;
      read = 1; write = 0; address = 4'd2;
      q.push_back('{data: 32'hFFFF_FFFF, cyc: cyc + RL, tag: 12});
      idle(3);
      op(1, 0, 3, 0, 32'h1, 13);
      idle(2);

      // LO then HI back to back across a carry
      @(negedge clk);
      dut.cnt_q = 64'h0000_0005_FFFF_FFFF;
      read = 1; write = 0; address = 4'd2;
      q.push_back('{data: 32'hFFFF_FFFF, cyc: cyc + RL, tag: 14});
      op(1, 0, 3, 0, 32'h5, 15);
      idle(2);

      // 64-bit wrap to zero
      @(negedge clk);
      dut.cnt_q = 64'hFFFF_FFFF_FFFF_FFFF;
      read = 0; write = 0;
      op(1, 0, 2, 0, 32'h0, 16);
      op(1, 0, 3, 0, 32'h0, 17);
      idle(3);

      // in-flight read discarded by reset, then exact uptime
      @(negedge clk);
      read3 = 1; address3 = 4'd2;
      @(negedge clk);
      read3 = 0; rst3 = 1'b1;
      repeat (2) @(negedge clk);
      rst3 = 1'b0;
      rel = cyc;
      repeat (5) @(negedge clk);
      read3 = 1; address3 = 4'd2;
      q3.push_back('{data: 32'(cyc - rel), cyc: cyc + RL3, tag: 18});
      @(negedge clk);
      read3 = 0;

      idle(8);
      chk("pending", 0, 64'(q.size()), 64'h0);
      chk("dut3_pending", 0, 64'(q3.size()), 64'h0);
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
